// File: rtl/md_pkg.sv
// Shared constants for the mul/div issue controller: FSM state encoding,
// the $rstatus register index and the ISA exception codes.
package md_pkg;

    typedef logic [1:0] md_state_t;

    localparam md_state_t ST_IDLE   = 2'd0;
    localparam md_state_t ST_LAUNCH = 2'd1;
    localparam md_state_t ST_WAIT   = 2'd2;
    localparam md_state_t ST_DONE   = 2'd3;

    localparam logic [4:0] RSTATUS_REG  = 5'd30;
    localparam logic [2:0] MUL_EXC_CODE = 3'd4;
    localparam logic [2:0] DIV_EXC_CODE = 3'd5;

    function automatic logic [2:0] exc_code(input logic is_div);
        return is_div ? DIV_EXC_CODE : MUL_EXC_CODE;
    endfunction

endpackage

// File: rtl/md_watchdog.sv
// Resettable up-counter with clear and terminal-count flag; bounds the WAIT
// state when MD_WATCHDOG_EN is defined (the module only exists in that build).
`ifdef MD_WATCHDOG_EN
module md_watchdog #(
    parameter int LIMIT = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // Saturates at LIMIT so tc stays asserted until the owner clears it.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tc_o = (cnt_q == CW'(LIMIT));

endmodule
`endif

// File: rtl/multdiv_issue_ctrl.sv
// Launches one mul/div operation, holds its operands, stalls until the unit is
// ready and emits one writeback. MD_WATCHDOG_EN adds a WAIT timeout.
module multdiv_issue_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int WD_LIMIT = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       rd,
    input  logic             flush,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    output logic             mult_start,
    output logic             div_start,
    input  logic [WIDTH-1:0] mult_result,
    input  logic [WIDTH-1:0] div_result,
    input  logic             mult_ready,
    input  logic             div_ready,
    input  logic             mult_exc,
    input  logic             div_exc,
    output logic             stall,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data
);

    md_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [4:0]       rd_q, rd_d;
    logic             div_q, div_d, exc_q, exc_d;

    logic             unit_ready;
    logic             unit_exc;
    logic [WIDTH-1:0] unit_res;
    logic             wd_tc;

    assign unit_ready = div_q ? div_ready  : mult_ready;
    assign unit_exc   = div_q ? div_exc    : mult_exc;
    assign unit_res   = div_q ? div_result : mult_result;

`ifdef MD_WATCHDOG_EN
    md_watchdog #(.LIMIT(WD_LIMIT)) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_q != ST_WAIT),
        .en_i  (state_q == ST_WAIT),
        .tc_o  (wd_tc)
    );
`else
    assign wd_tc = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        div_d   = div_q;
        res_d   = res_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    rd_d    = rd;
                    div_d   = is_div;
                    state_d = ST_LAUNCH;
                end
            end
            // Ready may still be high from the previous operation here.
            ST_LAUNCH: state_d = flush ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (unit_ready) begin
                    res_d   = unit_res;
                    exc_d   = unit_exc;
                    state_d = ST_DONE;
                end else if (wd_tc) begin
                    exc_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            div_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            div_q   <= div_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    // Operands only change on acceptance, so the divider sees stable signs.
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign mult_start = (state_q == ST_LAUNCH) && !div_q;
    assign div_start  = (state_q == ST_LAUNCH) &&  div_q;
    assign stall      = ((state_q == ST_IDLE) && start && !flush)
                      || (state_q == ST_LAUNCH) || (state_q == ST_WAIT);

    assign wb_valid = (state_q == ST_DONE) && !flush && (exc_q || (rd_q != 5'd0));
    assign wb_rd    = (state_q != ST_DONE) ? 5'd0 : (exc_q ? RSTATUS_REG : rd_q);
    assign wb_data  = (state_q != ST_DONE) ? '0
                    : (exc_q ? WIDTH'(exc_code(div_q)) : res_q);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed and randomized transactions against a cycle-count model of the
// mul/div issue controller.
module tb_multdiv_issue_ctrl;
    localparam int WIDTH    = 32;
    localparam int WD_LIMIT = 40;

    logic             clk = 1'b0;
    logic             reset;
    logic             start, is_div, flush;
    logic [WIDTH-1:0] op_a, op_b;
    logic [4:0]       rd;
    logic [WIDTH-1:0] unit_a, unit_b;
    logic             mult_start, div_start;
    logic [WIDTH-1:0] mult_result, div_result;
    logic             mult_ready, div_ready, mult_exc, div_exc;
    logic             stall, wb_valid;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    multdiv_issue_ctrl #(.WIDTH(WIDTH), .WD_LIMIT(WD_LIMIT)) dut (
        .clk(clk), .reset(reset), .start(start), .is_div(is_div),
        .op_a(op_a), .op_b(op_b), .rd(rd), .flush(flush),
        .unit_a(unit_a), .unit_b(unit_b),
        .mult_start(mult_start), .div_start(div_start),
        .mult_result(mult_result), .div_result(div_result),
        .mult_ready(mult_ready), .div_ready(div_ready),
        .mult_exc(mult_exc), .div_exc(div_exc),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        start = 0; is_div = 0; flush = 0; op_a = '0; op_b = '0; rd = '0;
        mult_ready = 0; div_ready = 0; mult_exc = 0; div_exc = 0;
        mult_result = '0; div_result = '0;
    endtask

    // One instruction issued at cycle 0. The unit answers 2+d cycles later
    // (never if noready); flush_at < 0 means no flush.
    task automatic run_op(input bit dv, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input int d, input bit ex,
                          input logic [31:0] res, input int flush_at,
                          input bit stale0, input bit noready);
        int  rdy_cyc  = noready ? -1 : 2 + d;
        int  done_cyc = 3 + d;
        bit  aborted  = (flush_at >= 0) && (flush_at <= 2 + d);
        int  last     = aborted ? flush_at : 4 + d;
        bit  writes   = ex || (r != 5'd0);
        bit  stale, e_stall, e_pulse, e_wb;
        for (int c = 0; c <= last; c++) begin
            stale  = (c == 1) || (c == 0 && stale0);
            start  = (c == 0);
            is_div = (c == 0) ? dv : 1'($urandom);
            op_a   = (c == 0) ? a : $urandom;
            op_b   = (c == 0) ? b : $urandom;
            rd     = (c == 0) ? r : 5'($urandom);
            flush  = (c == flush_at);
            if (dv) begin
                div_ready   = (c == rdy_cyc) || stale;
                div_exc     = (c == rdy_cyc) ? ex : 1'($urandom);
                div_result  = (c == rdy_cyc) ? res : $urandom;
                mult_ready  = 1'($urandom);
                mult_exc    = 1'($urandom);
                mult_result = $urandom;
            end else begin
                mult_ready  = (c == rdy_cyc) || stale;
                mult_exc    = (c == rdy_cyc) ? ex : 1'($urandom);
                mult_result = (c == rdy_cyc) ? res : $urandom;
                div_ready   = 1'($urandom);
                div_exc     = 1'($urandom);
                div_result  = $urandom;
            end
            @(negedge clk);
            e_stall = (c == 0) ? (flush_at != 0) : (c <= 2 + d);
            e_pulse = (c == 1) && (flush_at != 0);
            e_wb    = (c == done_cyc) && !aborted && (flush_at != done_cyc) && writes;
            chk("stall", 32'(stall), 32'(e_stall));
            chk("mult_start", 32'(mult_start), 32'(e_pulse && !dv));
            chk("div_start", 32'(div_start), 32'(e_pulse && dv));
            chk("wb_valid", 32'(wb_valid), 32'(e_wb));
            if (e_wb) begin
                chk("wb_rd", 32'(wb_rd), ex ? 32'd30 : 32'(r));
                chk("wb_data", wb_data, ex ? (dv ? 32'd5 : 32'd4) : res);
            end
            if (c >= 1 && flush_at != 0) begin
                chk("unit_a", unit_a, a);
                chk("unit_b", unit_b, b);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        $display("[TB] op %s a=%0h b=%0h rd=%0d delay=%0d exc=%0d flush_at=%0d done",
                 dv ? "div" : "mul", a, b, r, d, ex, flush_at);
    endtask

    initial begin
        bit          dv, ex, prev_ab;
        logic [31:0] a, b, res;
        logic [4:0]  r;
        int          d, fa;

        idle_inputs();
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_unit_a", unit_a, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_starts", 32'({mult_start, div_start}), 0);
        @(posedge clk); #1;

        // mul 6*7, ready 10 cycles after launch
        run_op(0, 32'd6, 32'd7, 5'd3, 9, 0, 32'd42, -1, 0, 0);
        // div -20/3 with garbage operands after issue
        a = 32'hFFFF_FFEC; b = 32'd3; res = 32'(int'(a) / int'(b));
        run_op(1, a, b, 5'd7, 5, 0, res, -1, 0, 0);
        // divide by zero -> $rstatus
        run_op(1, 32'd5, 32'd0, 5'd9, 3, 1, 32'hDEAD_BEEF, -1, 0, 0);
        // rd==0 without exception: no writeback
        run_op(0, 32'd3, 32'd4, 5'd0, 2, 0, 32'd12, -1, 0, 0);
        // flush in WAIT, then new start alongside a stale ready
        run_op(1, 32'd100, 32'd7, 5'd5, 6, 0, 32'd14, 4, 0, 0);
        run_op(0, 32'd2, 32'd3, 5'd4, 1, 0, 32'd6, -1, 1, 0);
        // flush beats start in IDLE, flush in LAUNCH, flush in DONE
        run_op(0, 32'd8, 32'd8, 5'd6, 2, 0, 32'd64, 0, 0, 0);
        run_op(1, 32'd9, 32'd3, 5'd6, 2, 0, 32'd3, 1, 1, 0);
        run_op(0, 32'd9, 32'd9, 5'd8, 2, 0, 32'd81, 5, 1, 0);

        // reset in WAIT clears everything on the next edge
        start = 1; is_div = 1; op_a = 32'h1234; op_b = 32'h56; rd = 5'd11;
        @(posedge clk); #1;
        idle_inputs();
        repeat (2) begin @(posedge clk); #1; end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rstw_stall", 32'(stall), 0);
        chk("rstw_unit_a", unit_a, 0);
        chk("rstw_unit_b", unit_b, 0);
        chk("rstw_wb", 32'({wb_valid, wb_rd}), 0);
        chk("rstw_wb_data", wb_data, 0);
        chk("rstw_starts", 32'({mult_start, div_start}), 0);
        @(posedge clk); #1;

`ifdef MD_WATCHDOG_EN
        run_op(0, 32'd1, 32'd2, 5'd12, WD_LIMIT, 1, 32'd0, -1, 0, 1);
        run_op(1, 32'd1, 32'd2, 5'd12, WD_LIMIT, 1, 32'd0, -1, 0, 1);
`endif

        prev_ab = 0;
        for (int t = 0; t < 40; t++) begin
            dv = 1'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            r  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            d  = $urandom_range(0, 12);
            if (dv) begin
                ex  = (b == 0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
                res = ex ? $urandom : 32'(int'(a) / int'(b));
            end else begin
                ex  = ($urandom_range(0, 5) == 0);
                res = a * b;
            end
            fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3 + d) : -1;
            run_op(dv, a, b, r, d, ex, res, fa, prev_ab, 0);
            prev_ab = (fa >= 0) && (fa <= 2 + d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
